// File: rtl/tla_pkg.sv
// Shared types and constants for the open/close compare-command scheduler.
package tla_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        FIRE  = 3'd2,
        GUARD = 3'd3,
        ACK   = 3'd4
    } state_t;

    localparam logic OP_OPEN   = 1'b0;
    localparam logic OP_CLOSE  = 1'b1;
    localparam int   SETUP_CYC = 2;
    localparam int   CNT_W     = 16;

endpackage

// File: rtl/tla_rr_arb2.sv
// Two-input round-robin arbiter: grants one requester while enabled and
// remembers the last granted requester to break ties.
module tla_rr_arb2
    import tla_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] vld,
    output logic [1:0] rdy
);

    logic       ptr_r;
    logic [1:0] rdy_s;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        rdy_s = 2'b00;
        if (en) begin
            case (vld)
                2'b01:   rdy_s = 2'b01;
                2'b10:   rdy_s = 2'b10;
                2'b11:   rdy_s = ptr_r ? 2'b01 : 2'b10;
                default: rdy_s = 2'b00;
            endcase
        end else begin
            rdy_s = 2'b00;
        end
    end

    // Last-granted pointer; starts at 1 so req0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= 1'b1;
        end else if (|(vld & rdy_s)) begin
            ptr_r <= rdy_s[1];
        end
    end

    assign rdy = rdy_s;

endmodule

// File: rtl/tla_com_sched.sv
// Compare-command scheduler: arbitrates host/scan requests and issues a guarded
// open/close strobe. Define TLA_SCHED_ACK_EN to build the Gc_wdis echo check.
module tla_com_sched #(
    parameter int TOP0_0 = 3,
    parameter int LDD0_0 = 32,
    parameter int GUARD  = 8,
    parameter int TMO    = 1023
) (
    input  logic              Gc_clk125,
    input  logic              Gc_rst,
    input  logic              req0_vld,
    input  logic              req0_op,
    input  logic [TOP0_0-1:0] req0_wdis,
    input  logic [LDD0_0-1:0] req0_plus,
    output logic              req0_rdy,
    input  logic              req1_vld,
    input  logic              req1_op,
    input  logic [TOP0_0-1:0] req1_wdis,
    input  logic [LDD0_0-1:0] req1_plus,
    output logic              req1_rdy,
    output logic [TOP0_0-1:0] Gc_com_wdis,
    output logic [LDD0_0-1:0] Gc_com_plus,
    output logic              Gc_com_open,
    output logic              Gc_com_close,
    input  logic [TOP0_0-1:0] Gc_wdis,
    output logic              busy,
    output logic              gnt_id,
    output logic              done,
    output logic              err
);
    import tla_pkg::*;

    state_t              state_r, nxt_state_s;
    logic [CNT_W-1:0]    cnt_r, nxt_cnt_s;
    logic                op_r, nxt_op_s;
    logic [TOP0_0-1:0]   wdis_r, nxt_wdis_s;
    logic [LDD0_0-1:0]   plus_r, nxt_plus_s;
    logic                open_r, nxt_open_s;
    logic                close_r, nxt_close_s;
    logic                gnt_r, nxt_gnt_s;
    logic                done_r, nxt_done_s;
    logic                err_r, nxt_err_s;
    logic                busy_r;
    logic [1:0]          rdy_s;
    logic                xfer_s;
    logic                idle_s;

    assign idle_s = (state_r == IDLE);

    tla_rr_arb2 u_arb (
        .clk (Gc_clk125),
        .rst (Gc_rst),
        .en  (idle_s),
        .vld ({req1_vld, req0_vld}),
        .rdy (rdy_s)
    );

    assign xfer_s = |({req1_vld, req0_vld} & rdy_s);

`ifdef TLA_SCHED_ACK_EN
    logic match_r;

    // Echo compare registered once before the FSM looks at it.
    always_ff @(posedge Gc_clk125 or posedge Gc_rst) begin
        if (Gc_rst) begin
            match_r <= 1'b0;
        end else begin
            match_r <= (Gc_wdis == wdis_r);
        end
    end
`else
    logic unused_ack_s;
    assign unused_ack_s = ^{Gc_wdis, 16'(TMO)};
`endif

    // Next-state and next-output decode for the command sequence.
    always_comb begin
        nxt_state_s = state_r;
        nxt_cnt_s   = cnt_r;
        nxt_op_s    = op_r;
        nxt_wdis_s  = wdis_r;
        nxt_plus_s  = plus_r;
        nxt_gnt_s   = gnt_r;
        nxt_open_s  = 1'b0;
        nxt_close_s = 1'b0;
        nxt_done_s  = 1'b0;
        nxt_err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (xfer_s) begin
                    nxt_state_s = SETUP;
                    nxt_cnt_s   = {CNT_W{1'b0}};
                    nxt_gnt_s   = rdy_s[1];
                    nxt_op_s    = rdy_s[1] ? req1_op   : req0_op;
                    nxt_wdis_s  = rdy_s[1] ? req1_wdis : req0_wdis;
                    nxt_plus_s  = rdy_s[1] ? req1_plus : req0_plus;
                end else begin
                    nxt_state_s = IDLE;
                end
            end
            SETUP: begin
                if (cnt_r == CNT_W'(SETUP_CYC - 1)) begin
                    nxt_state_s = FIRE;
                    nxt_cnt_s   = {CNT_W{1'b0}};
                    nxt_open_s  = (op_r == OP_OPEN);
                    nxt_close_s = (op_r == OP_CLOSE);
                end else begin
                    nxt_cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            FIRE: begin
                nxt_state_s = tla_pkg::GUARD;
                nxt_cnt_s   = {CNT_W{1'b0}};
            end
            tla_pkg::GUARD: begin
                if (cnt_r == CNT_W'(GUARD - 1)) begin
                    nxt_cnt_s   = {CNT_W{1'b0}};
`ifdef TLA_SCHED_ACK_EN
                    nxt_state_s = ACK;
`else
                    nxt_state_s = IDLE;
                    nxt_done_s  = 1'b1;
`endif
                end else begin
                    nxt_cnt_s   = cnt_r + CNT_W'(1);
                end
            end
`ifdef TLA_SCHED_ACK_EN
            ACK: begin
                if (match_r) begin
                    nxt_state_s = IDLE;
                    nxt_cnt_s   = {CNT_W{1'b0}};
                    nxt_done_s  = 1'b1;
                end else if (cnt_r == CNT_W'(TMO - 1)) begin
                    nxt_state_s = IDLE;
                    nxt_cnt_s   = {CNT_W{1'b0}};
                    nxt_done_s  = 1'b1;
                    nxt_err_s   = 1'b1;
                end else begin
                    nxt_cnt_s   = cnt_r + CNT_W'(1);
                end
            end
`endif
            default: begin
                nxt_state_s = IDLE;
                nxt_cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, latched command and registered outputs.
    always_ff @(posedge Gc_clk125 or posedge Gc_rst) begin
        if (Gc_rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            op_r    <= 1'b0;
            wdis_r  <= {TOP0_0{1'b0}};
            plus_r  <= {LDD0_0{1'b0}};
            gnt_r   <= 1'b0;
            open_r  <= 1'b0;
            close_r <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= nxt_state_s;
            cnt_r   <= nxt_cnt_s;
            op_r    <= nxt_op_s;
            wdis_r  <= nxt_wdis_s;
            plus_r  <= nxt_plus_s;
            gnt_r   <= nxt_gnt_s;
            open_r  <= nxt_open_s;
            close_r <= nxt_close_s;
            done_r  <= nxt_done_s;
            err_r   <= nxt_err_s;
            busy_r  <= (nxt_state_s != IDLE);
        end
    end

    assign req0_rdy     = rdy_s[0];
    assign req1_rdy     = rdy_s[1];
    assign Gc_com_wdis  = wdis_r;
    assign Gc_com_plus  = plus_r;
    assign Gc_com_open  = open_r;
    assign Gc_com_close = close_r;
    assign busy         = busy_r;
    assign gnt_id       = gnt_r;
    assign done         = done_r;
    assign err          = err_r;

endmodule

// File: tb/tb_tla_com_sched.sv
// Directed bench for tla_com_sched; ACK scenarios are included when
// TLA_SCHED_ACK_EN is defined.
module tb_tla_com_sched;

    localparam int TOP0_0 = 3;
    localparam int LDD0_0 = 32;
    localparam int GUARD  = 8;
    localparam int TMO    = 1023;
`ifdef TLA_SCHED_ACK_EN
    localparam int ACK_LAT = 1;
`else
    localparam int ACK_LAT = 0;
`endif
    localparam int DONE_K  = GUARD + 3 + ACK_LAT;
    localparam int SPACING = GUARD + 4 + ACK_LAT;

    logic              clk;
    logic              rst;
    logic              req0_vld, req0_op, req0_rdy;
    logic [TOP0_0-1:0] req0_wdis;
    logic [LDD0_0-1:0] req0_plus;
    logic              req1_vld, req1_op, req1_rdy;
    logic [TOP0_0-1:0] req1_wdis;
    logic [LDD0_0-1:0] req1_plus;
    logic [TOP0_0-1:0] Gc_com_wdis;
    logic [LDD0_0-1:0] Gc_com_plus;
    logic              Gc_com_open, Gc_com_close;
    logic [TOP0_0-1:0] Gc_wdis;
    logic              busy, gnt_id, done, err;

    logic              echo_auto;
    logic [TOP0_0-1:0] echo_val;

    int n_chk;
    int n_pass;

    // Remote-side model: either echoes the issued wdis or a forced value.
    assign Gc_wdis = echo_auto ? Gc_com_wdis : echo_val;

    tla_com_sched #(
        .TOP0_0 (TOP0_0),
        .LDD0_0 (LDD0_0),
        .GUARD  (GUARD),
        .TMO    (TMO)
    ) dut (
        .Gc_clk125    (clk),
        .Gc_rst       (rst),
        .req0_vld     (req0_vld),
        .req0_op      (req0_op),
        .req0_wdis    (req0_wdis),
        .req0_plus    (req0_plus),
        .req0_rdy     (req0_rdy),
        .req1_vld     (req1_vld),
        .req1_op      (req1_op),
        .req1_wdis    (req1_wdis),
        .req1_plus    (req1_plus),
        .req1_rdy     (req1_rdy),
        .Gc_com_wdis  (Gc_com_wdis),
        .Gc_com_plus  (Gc_com_plus),
        .Gc_com_open  (Gc_com_open),
        .Gc_com_close (Gc_com_close),
        .Gc_wdis      (Gc_wdis),
        .busy         (busy),
        .gnt_id       (gnt_id),
        .done         (done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int acc_cyc [8];
    int acc_id  [8];
    int acc_dn  [8];
    int str_cyc [8];
    int str_cls [8];
    int str_wd  [8];
    int n_acc, n_str, n_both, n_open, seen1, done_k, err_at;

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        echo_auto = 1'b1;
        echo_val = 3'd0;
        req0_vld = 1'b0; req0_op = 1'b0; req0_wdis = 3'd0; req0_plus = 32'd0;
        req1_vld = 1'b0; req1_op = 1'b0; req1_wdis = 3'd0; req1_plus = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        step();

        // reset state
        check("rst_open",  Gc_com_open,  1'b0);
        check("rst_close", Gc_com_close, 1'b0);
        check("rst_wdis",  Gc_com_wdis,  3'd0);
        check("rst_plus",  Gc_com_plus,  32'd0);
        check("rst_busy",  busy,         1'b0);
        check("rst_done",  done,         1'b0);
        check("rst_err",   err,          1'b0);
        check("rst_gnt",   gnt_id,       1'b0);

        // single req0 open
        req0_vld = 1'b1; req0_op = 1'b0; req0_wdis = 3'd5; req0_plus = 32'h0000_1234;
        #1;
        check("t1_rdy0", req0_rdy, 1'b1);
        check("t1_rdy1", req1_rdy, 1'b0);
        for (int k = 0; k < DONE_K + 3; k++) begin
            step();
            if (k == 0) req0_vld = 1'b0;
            check($sformatf("t1_open_k%0d", k),  Gc_com_open,  (k == 2));
            check($sformatf("t1_close_k%0d", k), Gc_com_close, 1'b0);
            check($sformatf("t1_done_k%0d", k),  done,         (k == DONE_K));
            check($sformatf("t1_busy_k%0d", k),  busy,         (k < DONE_K));
            check($sformatf("t1_err_k%0d", k),   err,          1'b0);
        end
        check("t1_wdis_hold", Gc_com_wdis, 3'd5);
        check("t1_plus_hold", Gc_com_plus, 32'h0000_1234);
        check("t1_gnt",       gnt_id,      1'b0);

        // asynchronous reset during FIRE
        req0_vld = 1'b1; req0_op = 1'b0; req0_wdis = 3'd6; req0_plus = 32'h0000_5678;
        step();
        req0_vld = 1'b0;
        step();
        step();
        check("rf_open_before", Gc_com_open, 1'b1);
        check("rf_wdis_before", Gc_com_wdis, 3'd6);
        #1 rst = 1'b1;
        #1;
        check("rf_open",  Gc_com_open,  1'b0);
        check("rf_close", Gc_com_close, 1'b0);
        check("rf_wdis",  Gc_com_wdis,  3'd0);
        check("rf_plus",  Gc_com_plus,  32'd0);
        check("rf_busy",  busy,         1'b0);
        check("rf_done",  done,         1'b0);
        check("rf_err",   err,          1'b0);
        check("rf_gnt",   gnt_id,       1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // continuous tie: req0 close, req1 open
        req0_vld = 1'b1; req0_op = 1'b1; req0_wdis = 3'd1; req0_plus = 32'h0000_AAAA;
        req1_vld = 1'b1; req1_op = 1'b0; req1_wdis = 3'd2; req1_plus = 32'h0000_BBBB;
        #1;
        check("tie_first_rdy0", req0_rdy, 1'b1);
        check("tie_first_rdy1", req1_rdy, 1'b0);
        n_acc = 0; n_str = 0; n_both = 0;
        for (int c = 0; c < 60; c++) begin
            if (n_acc < 8 && ((req0_rdy && req0_vld) || (req1_rdy && req1_vld))) begin
                acc_cyc[n_acc] = c;
                acc_id[n_acc]  = req1_rdy ? 1 : 0;
                acc_dn[n_acc]  = done ? 1 : 0;
                n_acc++;
            end
            if (req0_rdy && req1_rdy) n_both++;
            if (Gc_com_open && Gc_com_close) n_both++;
            if (n_str < 8 && (Gc_com_open || Gc_com_close)) begin
                str_cyc[n_str] = c;
                str_cls[n_str] = Gc_com_close ? 1 : 0;
                str_wd[n_str]  = int'(Gc_com_wdis);
                n_str++;
            end
            step();
        end
        check("tie_n_acc_ge4", (n_acc >= 4), 1'b1);
        check("tie_no_double", n_both, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("tie_id%0d", i), acc_id[i], i % 2);
            check($sformatf("tie_strobe_at%0d", i), str_cyc[i], acc_cyc[i] + 3);
            check($sformatf("tie_strobe_cls%0d", i), str_cls[i], (i % 2 == 0) ? 1 : 0);
            check($sformatf("tie_strobe_wdis%0d", i), str_wd[i], (i % 2 == 0) ? 1 : 2);
            if (i > 0) begin
                check($sformatf("tie_spacing%0d", i), acc_cyc[i] - acc_cyc[i-1], SPACING);
                check($sformatf("tie_done_at_acc%0d", i), acc_dn[i], 1);
            end
        end
        req0_vld = 1'b0;
        req1_vld = 1'b0;
        repeat (20) step();

        // req1 pulses while busy and drops
        req0_vld = 1'b1; req0_op = 1'b0; req0_wdis = 3'd4; req0_plus = 32'h0000_0077;
        n_open = 0; seen1 = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (k == 0) req0_vld = 1'b0;
            if (Gc_com_open || Gc_com_close) n_open++;
            if (req1_rdy) seen1++;
            if (k == 3) begin
                req1_vld = 1'b1; req1_op = 1'b0; req1_wdis = 3'd7;
            end
            if (k == 4) req1_vld = 1'b0;
        end
        check("drop_strobes", n_open, 1);
        check("drop_rdy1",    seen1, 0);
        check("drop_gnt",     gnt_id, 1'b0);
        check("drop_busy",    busy, 1'b0);
        check("drop_wdis",    Gc_com_wdis, 3'd4);

`ifdef TLA_SCHED_ACK_EN
        // echo arrives 20 cycles after accept
        echo_auto = 1'b0; echo_val = 3'd0;
        step();
        req0_vld = 1'b1; req0_op = 1'b0; req0_wdis = 3'd3; req0_plus = 32'h0000_0009;
        done_k = -1; err_at = -1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (k == 0) req0_vld = 1'b0;
            if (done && done_k < 0) begin
                done_k = k;
                err_at = err ? 1 : 0;
            end
            if (k == 20) echo_val = 3'd3;
        end
        check("ack_done_k", done_k, 22);
        check("ack_err",    err_at, 0);

        // echo stuck at 0: timeout
        echo_val = 3'd0;
        step();
        req0_vld = 1'b1; req0_op = 1'b0; req0_wdis = 3'd3; req0_plus = 32'h0000_0009;
        done_k = -1; err_at = -1;
        for (int k = 0; k < GUARD + TMO + 40; k++) begin
            step();
            if (k == 0) req0_vld = 1'b0;
            if (done && done_k < 0) begin
                done_k = k;
                err_at = err ? 1 : 0;
            end
        end
        check("tmo_done_k", done_k, GUARD + 3 + TMO);
        check("tmo_err",    err_at, 1);
        echo_auto = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tla_com_sched.md
# tla_com_sched

Command scheduler in the Gc_clk125 domain for the open/close compare-command path into the 200 MHz acquisition domain. It arbitrates between two requesters: host register writes and the auto-scan engine. For each granted command it drives the Gc_com_wdis / Gc_com_plus levels, holds them stable around a single-cycle Gc_com_open or Gc_com_close strobe, and enforces a guard gap so the 200 MHz side has time to stretch and accept the strobe. Optionally it then confirms completion by watching the Gc_wdis echo.

## Interface
- TOP0_0, 3, width of wdis fields
- LDD0_0, 32, width of plus fields
- GUARD, 8, cycles between strobe and next state (legal range 1..255)
- TMO, 1023, ACK timeout in cycles (legal range 1..65535)
- Gc_clk125  in  1  125 MHz clock
- Gc_rst  in  1  asynchronous, active-high reset
- req0_vld / req1_vld  in  1  request valid (0 = host, 1 = scan)
- req0_op / req1_op  in  1  0 = open, 1 = close
- req0_wdis / req1_wdis  in  TOP0_0  window select
- req0_plus / req1_plus  in  LDD0_0  pulse parameter
- req0_rdy / req1_rdy  out  1  combinational accept; a transfer occurs on vld & rdy
- Gc_com_wdis  out  TOP0_0  registered level
- Gc_com_plus  out  LDD0_0  registered level
- Gc_com_open  out  1  one-cycle strobe
- Gc_com_close  out  1  one-cycle strobe
- Gc_wdis  in  TOP0_0  wdis echo returned from the 200 MHz side
- busy  out  1  high whenever state ≠ IDLE
- gnt_id  out  1  requester of the current or last command
- done  out  1  one-cycle pulse at command end
- err  out  1  one-cycle pulse on ACK timeout, coincident with done

## Operation
- States: IDLE → SETUP → FIRE → GUARD → ACK → IDLE. ACK exists only with the macro; without it GUARD → IDLE.
- IDLE arbitration:
  - rdy is asserted only in IDLE, to exactly one requester.
  - If only one vld is high, that requester gets rdy.
  - If both are high, round-robin: the requester other than the last granted gets rdy. After reset the last-granted pointer = 1, so req0 wins the first tie.
- On accept:
  - Latch op, wdis and plus.
  - Update gnt_id and the round-robin pointer.
  - Load Gc_com_wdis and Gc_com_plus on the same edge.
- SETUP: 2 cycles. Outputs are held so the levels are stable before the strobe.
- FIRE: 1 cycle. Gc_com_open = ~op; Gc_com_close = op. Never both.
- GUARD: counts GUARD cycles. Outputs are held.
- ACK:
  - Wait for Gc_wdis == latched wdis (compared combinationally and registered once) → done.
  - If the counter reaches TMO first → done + err.
  - Either way, go to IDLE.
- Gc_com_wdis and Gc_com_plus keep the last issued values after completion. The destination samples them as levels.
- Requests arriving while busy are not accepted and must be held by the requester.
- A requester that drops vld without a transfer is not granted.
- Reset (asynchronous, including mid-operation):
  - State returns to IDLE.
  - All outputs are 0: strobes, wdis, plus, busy, done, err, gnt_id.
  - The round-robin pointer returns to 1.
  - Counters clear.

## Timing
- Accept at edge T.
- Gc_com_wdis and Gc_com_plus are valid from T.
- Strobe is high for the cycle between edges T+2 and T+3.
- Without ACK: done is high for the cycle after edge T+3+GUARD; rdy returns in that same cycle. Minimum command spacing is GUARD+4 cycles.
- With ACK: the ACK counter starts at T+3+GUARD. done follows the first registered match by 1 cycle, or follows TMO cycles with err.
- A new accept can occur in the same cycle done is high.

## Configuration
- TLA_SCHED_ACK_EN defined: ACK state, echo compare and timeout are built; err is functional.
- TLA_SCHED_ACK_EN undefined: no ACK logic; Gc_wdis is unused; err is tied to 0.

## Structure
- Shared package tla_pkg holds:
  - state enum: IDLE, SETUP, FIRE, GUARD, ACK
  - op encodings: OP_OPEN = 0, OP_CLOSE = 1
  - SETUP_CYC = 2
- Sub-module tla_rr_arb2: two-input round-robin arbiter holding the pointer and producing the rdy vector. The rest of the block is a single FSM module.

## Test plan
- Single req0 open, wdis = 3'd5, plus = 32'h0000_1234 → accept at T; Gc_com_open high exactly at T+2..T+3; Gc_com_close stays 0; done at T+3+8; outputs keep 5 / 0x1234.
- Both vld held high continuously, req0 close and req1 open → grants alternate 0,1,0,1; spacing exactly GUARD+4 cycles without ACK.
- ACK_EN, Gc_wdis tracks the command after 20 cycles → done with err = 0. Gc_wdis stuck at 0 with wdis = 3 → done and err together, TMO cycles after ACK entry.
- Gc_rst asserted during FIRE → Gc_com_open drops immediately (asynchronous); all outputs 0; next tie goes to req0.
- req1_vld pulses for 1 cycle while busy, then drops → never granted; no strobe is issued for it.
